sd_cmd_tx: RTL

- Command-path transmitter that serialises one SD command frame onto the CMD line. The frame is 48 bits: start bit, transmission bit, 6-bit index, 32-bit argument, CRC7 and end bit.
- After the end bit it releases the line and, when the command expects a response, enables the downstream response receiver. It then waits for that receiver's finished flag or for a timeout.
- Sits between the host command controller (upstream) and the response receiver (downstream).

---
 rtl/sd_cmd_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx -- SD command-path transmitter.
//
// Serialises one 48-bit SD command frame onto the CMD line, MSB first:
//   start(0), transmission(1), index[5:0], argument[31:0], CRC7[6:0], end(1)
// After the end bit the line is released. If the command expects a response,
// the response receiver is enabled until it reports completion or until
// RESP_TIMEOUT cycles have passed, which sets the sticky timeout flag.
//
// Parameters
//   RESP_TIMEOUT  cycles allowed in WAIT_RESP before timeout (>= 2)
//   TO_W          timeout counter width, 2**TO_W > RESP_TIMEOUT
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          one-cycle request, sampled only in IDLE
//   cmd_index      6-bit command index, latched on accepted start
//   argument       32-bit argument, latched on accepted start
//   need_resp      command expects a response, latched on accepted start
//   resp_finished  completion flag from the response receiver
//   sd_cmd_out     serial CMD data
//   sd_cmd_oe      CMD line drive enable
//   resp_en        response receiver enable
//   busy           high in every state except IDLE
//   done           one-cycle pulse at transaction end
//   timeout        sticky response-timeout flag, cleared on next accepted start
module sd_cmd_tx #(
    parameter int RESP_TIMEOUT = 64,
    parameter int TO_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    input  logic        need_resp,
    input  logic        resp_finished,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        resp_en,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CRC,
        S_STOP,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [39:0]     r_shift;
    logic [6:0]      r_crc;
    logic [5:0]      r_bitcnt;
    logic [TO_W-1:0] r_tocnt;
    logic            r_need_resp;
    logic            r_timeout;

    logic            w_bit_last;
    logic            w_to_last;

    // One step of CRC7 (x^7 + x^3 + 1) over a single serial bit.
    function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign w_bit_last = (r_bitcnt == 6'd0);
    assign w_to_last  = (r_tocnt == TO_LAST);
    assign timeout    = r_timeout;

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        sd_cmd_out = 1'b1;
        sd_cmd_oe  = 1'b0;
        resp_en    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                sd_cmd_oe  = 1'b1;
                sd_cmd_out = r_shift[39];
                if (w_bit_last) w_next = S_CRC;
            end
            S_CRC: begin
                sd_cmd_oe  = 1'b1;
                sd_cmd_out = r_crc[6];
                if (w_bit_last) w_next = S_STOP;
            end
            S_STOP: begin
                sd_cmd_oe = 1'b1;
                w_next    = r_need_resp ? S_WAIT_RESP : S_DONE;
            end
            S_WAIT_RESP: begin
                resp_en = 1'b1;
                // A completion in the last allowed cycle still counts as a response.
                if (resp_finished || w_to_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Shift register, CRC, counters and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= '0;
            r_crc       <= '0;
            r_bitcnt    <= '0;
            r_tocnt     <= '0;
            r_need_resp <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift     <= {2'b01, cmd_index, argument};
                        r_crc       <= '0;
                        r_timeout   <= 1'b0;
                        r_bitcnt    <= 6'd39;
                        r_need_resp <= need_resp;
                    end
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[38:0], 1'b0};
                    r_crc   <= f_crc7_step(r_crc, r_shift[39]);
                    // Reload the counter for the 7 CRC bits on the last data bit.
                    r_bitcnt <= w_bit_last ? 6'd6 : r_bitcnt - 6'd1;
                end
                S_CRC: begin
                    r_crc <= {r_crc[5:0], 1'b0};
                    if (!w_bit_last) r_bitcnt <= r_bitcnt - 6'd1;
                end
                S_STOP: begin
                    r_tocnt <= '0;
                end
                S_WAIT_RESP: begin
                    r_tocnt <= r_tocnt + 1'b1;
                    if (!resp_finished && w_to_last) r_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
